// File: rtl/stopwatch_ctrl.sv
// Stopwatch control core: IDLE/RUN/PAUSE FSM, 10 ms prescaler, BCD mm:ss.cc
// live count with a split-hold register feeding a 6-digit display value.
module stopwatch_ctrl #(
  parameter int CLK_FREQ = 100000000,
  parameter int DIV      = CLK_FREQ / 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        split,
  input  logic        reset,
  output logic [23:0] disp,
  output logic        running,
  output logic        split_active,
  output logic        ovf
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [23:0]   live_q, live_d;
  logic [23:0]   split_q, split_d;
  logic          hold_q, hold_d;
  logic          ovf_q, ovf_d;

  logic          do_reset, do_stop, do_start, do_split;
  logic          tick;
  logic [23:0]   inc_time;
  logic          carry;

  // Digit order from LSB: c0, c1, s0, s1, m0, m1; tens of seconds/minutes stop at 5.
  function automatic logic [3:0] digit_max(input int idx);
    return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
  endfunction

  // Single-winner arbitration: reset > stop > start > split.
  assign do_reset = reset;
  assign do_stop  = stop & ~reset;
  assign do_start = start & ~stop & ~reset;
  assign do_split = split & ~start & ~stop & ~reset;

  assign tick = (state_q == S_RUN) && (presc_q == PRESC_MAX);

  always_comb begin
    inc_time = live_q;
    carry    = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (carry) begin
        if (live_q[i*4 +: 4] == digit_max(i)) begin
          inc_time[i*4 +: 4] = 4'd0;
        end else begin
          inc_time[i*4 +: 4] = live_q[i*4 +: 4] + 4'd1;
          carry              = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      live_q  <= '0;
      split_q <= '0;
      hold_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      live_q  <= live_d;
      split_q <= split_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    live_d  = live_q;
    split_d = split_q;
    hold_d  = hold_q;
    ovf_d   = ovf_q;

    // Counting follows the registered state, so a tick still lands in the stop cycle.
    if (state_q == S_RUN) begin
      if (tick) begin
        presc_d = '0;
        live_d  = inc_time;
        if (carry) ovf_d = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (do_start) begin
          state_d = S_RUN;
        end else if (do_reset) begin
          presc_d = '0;
          live_d  = '0;
          split_d = '0;
          hold_d  = 1'b0;
          ovf_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (do_stop) begin
          state_d = S_PAUSE;
        end else if (do_split) begin
          if (hold_q) begin
            hold_d = 1'b0;
          end else begin
            split_d = live_q;
            hold_d  = 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (do_reset) begin
          state_d = S_IDLE;
          presc_d = '0;
          live_d  = '0;
          split_d = '0;
          hold_d  = 1'b0;
          ovf_d   = 1'b0;
        end else if (do_start) begin
          state_d = S_RUN;
        end else if (do_split && hold_q) begin
          hold_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    running      = (state_q == S_RUN);
    split_active = hold_q;
    ovf          = ovf_q;
    disp         = hold_q ? split_q : live_q;
  end

endmodule
